// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_WR_WAIT,
        S_RESP
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int WR_TIMEOUT_DEF = 15;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/ram_arb_prio.sv
// Grant selection between fetch and LSU requesters.
// Fixed LSU priority by default; round-robin on ties when RAM_ARB_RR_EN is defined.
module ram_arb_prio
    import ram_arb_pkg::*;
(
    input  logic   if_valid_i,
    input  logic   lsu_valid_i,
    input  logic   idle_i,
    input  owner_e last_grant_i,
    output logic   gnt_if_o,
    output logic   gnt_lsu_o
);

    logic lsu_wins;

`ifdef RAM_ARB_RR_EN
    // On a tie the requester that was not granted last time wins.
    assign lsu_wins = lsu_valid_i & (~if_valid_i | (last_grant_i == OWN_IF));
`else
    logic unused_last;
    assign unused_last = last_grant_i;
    assign lsu_wins    = lsu_valid_i;
`endif

    assign gnt_lsu_o = idle_i & lsu_wins;
    assign gnt_if_o  = idle_i & if_valid_i & ~lsu_wins;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port (fetch / LSU) arbiter onto a single RAM with write-completion timeout.
// Define RAM_ARB_RR_EN for round-robin tie breaking instead of fixed LSU priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int WR_TIMEOUT = WR_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid_i,
    output logic              if_req_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_resp_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,

    input  logic              lsu_req_valid_i,
    output logic              lsu_req_ready_o,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0] lsu_wdata_i,
    input  logic [DATA_W-1:0] lsu_wmask_i,
    output logic              lsu_resp_valid_o,
    output logic              lsu_resp_err_o,
    output logic [DATA_W-1:0] lsu_rdata_o,

    output logic              ram_ren_o,
    output logic              ram_wen_o,
    output logic [ADDR_W-1:0] ram_raddr_o,
    output logic [ADDR_W-1:0] ram_waddr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [DATA_W-1:0] ram_wmask_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_bvalid_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(WR_TIMEOUT);

    state_e             state_q, state_d;
    owner_e             owner_q;
    owner_e             last_grant;
    logic [ADDR_W-1:0]  addr_q;
    logic               we_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  wmask_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic               flush_q;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  lsu_rdata_q;
    logic               gnt_if, gnt_lsu, accept, idle;
    logic               timed_out;

    // Readiness is held low while reset is asserted so every output is quiet.
    assign idle      = (state_q == S_IDLE) & rst;
    assign accept    = gnt_if | gnt_lsu;
    assign timed_out = ~ram_bvalid_i & (cnt_q == TIMEOUT_CNT);

    ram_arb_prio u_prio (
        .if_valid_i   (if_req_valid_i),
        .lsu_valid_i  (lsu_req_valid_i),
        .idle_i       (idle),
        .last_grant_i (last_grant),
        .gnt_if_o     (gnt_if),
        .gnt_lsu_o    (gnt_lsu)
    );

`ifdef RAM_ARB_RR_EN
    owner_e last_q;

    always_ff @(posedge clk) begin
        if (!rst)        last_q <= OWN_IF;
        else if (accept) last_q <= gnt_lsu ? OWN_LSU : OWN_IF;
    end

    assign last_grant = last_q;
`else
    assign last_grant = OWN_IF;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: the request payload registers are reset too; they are few and it keeps RAM-side outputs deterministic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q     <= OWN_IF;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            flush_q     <= 1'b0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
        end else begin
            if (accept) begin
                owner_q <= gnt_lsu ? OWN_LSU : OWN_IF;
                addr_q  <= gnt_lsu ? lsu_addr_i : if_addr_i;
                we_q    <= gnt_lsu & lsu_we_i;
                wdata_q <= lsu_wdata_i;
                wmask_q <= lsu_wmask_i;
                err_q   <= 1'b0;
                flush_q <= gnt_if & if_flush_i;
            end else if (if_flush_i && owner_q == OWN_IF && state_q != S_IDLE) begin
                flush_q <= 1'b1;
            end

            if (state_q == S_RD) begin
                if (owner_q == OWN_IF) if_rdata_q  <= ram_rdata_i;
                else                   lsu_rdata_q <= ram_rdata_i;
            end

            if (state_q == S_WR) begin
                cnt_q <= '0;
            end else if (state_q == S_WR_WAIT && !ram_bvalid_i && !timed_out) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == S_WR_WAIT && timed_out) err_q <= 1'b1;
        end
    end

    // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_lsu)     state_d = lsu_we_i ? S_WR : S_RD;
                else if (gnt_if) state_d = S_RD;
            end
            S_RD:      state_d = S_RESP;
            S_WR:      state_d = S_WR_WAIT;
            S_WR_WAIT: if (ram_bvalid_i || timed_out) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_ren_o        = 1'b0;
        ram_wen_o        = 1'b0;
        ram_raddr_o      = '0;
        ram_waddr_o      = '0;
        ram_wdata_o      = '0;
        ram_wmask_o      = '0;
        if_resp_valid_o  = 1'b0;
        lsu_resp_valid_o = 1'b0;
        lsu_resp_err_o   = 1'b0;
        case (state_q)
            S_RD: begin
                ram_ren_o   = ~we_q;
                ram_raddr_o = addr_q;
            end
            S_WR: begin
                ram_wen_o   = we_q;
                ram_waddr_o = addr_q;
                ram_wdata_o = wdata_q;
                ram_wmask_o = wmask_q;
            end
            S_RESP: begin
                if (owner_q == OWN_IF) begin
                    // A flush in the response cycle itself still cancels the fetch.
                    if_resp_valid_o = ~flush_q & ~if_flush_i;
                end else begin
                    lsu_resp_valid_o = 1'b1;
                    lsu_resp_err_o   = err_q;
                end
            end
            default: ;
        endcase
    end

    assign if_req_ready_o  = gnt_if;
    assign lsu_req_ready_o = gnt_lsu;
    assign if_rdata_o      = if_rdata_q;
    assign lsu_rdata_o     = lsu_rdata_q;

endmodule
